// File: rtl/pe_filter_rx.sv
`default_nettype none
// ============================================================================
// Module   : pe_filter_rx
// Purpose  : PE-side filter packet receiver; captures one filter row addressed
//            to this PE and forwards all other packets to the next hop.
// Revision : 1.0 - initial release
// ============================================================================
module pe_filter_rx #(
  parameter int         WIDTH_DATA  = 13,
  parameter int         WIDTH_F     = 5,
  parameter logic [1:0] FILTER_TYPE = 2'b00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            my_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  output logic                  fwd_valid,
  input  logic                  fwd_ready,
  output logic [31:0]           fwd_data,
  output logic                  row_valid,
  input  logic [2:0]            rd_idx,
  output logic [WIDTH_DATA-1:0] rd_data,
  input  logic                  row_release,
  output logic [3:0]            fill_count,
  output logic                  bad_idx
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  localparam logic [7:0] C_WIDTH_F = 8'(WIDTH_F);

  state_t                state_q, state_d;
  logic [WIDTH_DATA-1:0] entries_q [WIDTH_F];
  logic [WIDTH_DATA-1:0] entries_d [WIDTH_F];
  logic [WIDTH_F-1:0]    loaded_q, loaded_d;
  logic [3:0]            fill_count_q, fill_count_d;
  logic                  bad_idx_q, bad_idx_d;

  logic                  w_match;
  logic                  w_accept;
  logic                  w_idx_ok;
  logic [7:0]            w_idx;
  logic [WIDTH_DATA-1:0] w_value;
  logic                  unused_rsvd;

  // Bit 31 is reserved and plays no part in routing.
  assign unused_rsvd = in_data[31];

  assign w_match  = (in_data[30:29] == FILTER_TYPE) && (in_data[28:21] == my_addr);
  assign w_idx    = in_data[20:13];
  assign w_value  = in_data[WIDTH_DATA-1:0];
  assign w_idx_ok = (w_idx < C_WIDTH_F);

  // Routing is decided from in_data alone, which upstream holds while stalled.
  assign in_ready  = w_match ? (state_q == ST_FILL) : fwd_ready;
  assign fwd_valid = in_valid && !w_match;
  assign fwd_data  = in_data;
  assign w_accept  = in_valid && in_ready && w_match;

  assign row_valid  = (state_q == ST_FULL);
  assign fill_count = fill_count_q;
  assign bad_idx    = bad_idx_q;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < WIDTH_F; i++) begin
      if (rd_idx == 3'(i)) rd_data = entries_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    entries_d    = entries_q;
    loaded_d     = loaded_q;
    fill_count_d = fill_count_q;
    bad_idx_d    = bad_idx_q;
    case (state_q)
      ST_FILL: begin
        if (w_accept) begin
          if (w_idx_ok) begin
            for (int i = 0; i < WIDTH_F; i++) begin
              if (w_idx == 8'(i)) begin
                entries_d[i] = w_value;
                loaded_d[i]  = 1'b1;
                if (!loaded_q[i]) fill_count_d = fill_count_q + 4'd1;
              end
            end
            if (&loaded_d) state_d = ST_FULL;
          end else begin
            bad_idx_d = 1'b1;
          end
        end
      end
      ST_FULL: begin
        // Entries keep their old values; only the bookkeeping is cleared.
        if (row_release) begin
          state_d      = ST_FILL;
          loaded_d     = '0;
          fill_count_d = 4'd0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FILL;
      loaded_q     <= '0;
      fill_count_q <= 4'd0;
      bad_idx_q    <= 1'b0;
      for (int i = 0; i < WIDTH_F; i++) entries_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      loaded_q     <= loaded_d;
      fill_count_q <= fill_count_d;
      bad_idx_q    <= bad_idx_d;
      for (int i = 0; i < WIDTH_F; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule
`default_nettype wire
